fetch_sequencer: RTL and testbench

- Controller for the instruction-fetch stage. Owns the program counter and drives the ROM address and the IF/ID write/flush controls.
- Resolves redirect sources (taken branch, jump), hazard stalls and halt/resume with a small FSM. The fetch datapath becomes a pure address-to-instruction path under its control.
- Sits between the hazard unit / ID-EX branch logic and the ROM + IF/ID register.

---
 rtl/mips_fetch_pkg.sv | 21 ++
 rtl/fetch_perf_counter.sv | 22 ++
 rtl/fetch_sequencer.sv | 122 ++++++++++++
 tb/tb_fetch_sequencer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch sequencer.
package mips_fetch_pkg;

  localparam int unsigned ADDR_W_DEF       = 10;
  localparam int unsigned FLUSH_CYCLES_DEF = 2;
  localparam int unsigned OPCODE_W         = 6;
  localparam int unsigned CNT_W            = 16;
  localparam int unsigned STATE_W          = 3;
  localparam int unsigned FLUSH_CNT_W      = 3;

  localparam logic [OPCODE_W-1:0] HALT_OP_DEF = 6'b111111;

  typedef enum logic [STATE_W-1:0] {
    BOOT  = 3'd0,
    RUN   = 3'd1,
    STALL = 3'd2,
    FLUSH = 3'd3,
    HALT  = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/fetch_perf_counter.sv
// Saturating perf counter with synchronous active-low clear.
// Only present when FETCH_PERF_COUNTERS_EN is defined.
`ifdef FETCH_PERF_COUNTERS_EN
module fetch_perf_counter
  import mips_fetch_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(negedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule
`endif

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the pc and drives ROM address and IF/ID write/flush.
// Optional perf counters are built when FETCH_PERF_COUNTERS_EN is defined.
module fetch_sequencer
  import mips_fetch_pkg::*;
#(
  parameter int unsigned          ADDR_W       = ADDR_W_DEF,
  parameter int unsigned          FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter logic [OPCODE_W-1:0]  HALT_OP      = HALT_OP_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                branch_taken,
  input  logic [ADDR_W-1:0]   branch_target,
  input  logic                jump_req,
  input  logic [ADDR_W-1:0]   jump_target,
  input  logic                stall_req,
  input  logic [OPCODE_W-1:0] if_opcode,
  input  logic                resume,
  output logic [ADDR_W-1:0]   rom_addr,
  output logic                ifid_write,
  output logic                ifid_flush,
  output logic [STATE_W-1:0]  fsm_state,
  output logic [CNT_W-1:0]    stall_cycles,
  output logic [CNT_W-1:0]    flush_cycles
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
  localparam fetch_state_e           BRANCH_STATE = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

  fetch_state_e            state, state_nxt;
  logic [ADDR_W-1:0]       pc, pc_nxt;
  logic [FLUSH_CNT_W-1:0]  flush_cnt, flush_cnt_nxt;

  // State, pc and flush countdown; the whole fetch stage updates on the falling edge.
  always_ff @(negedge clk) begin
    if (!reset) begin
      state     <= BOOT;
      pc        <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  // Next state: a taken branch outranks everything once out of BOOT.
  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    flush_cnt_nxt = flush_cnt;
    if ((state != BOOT) && branch_taken) begin
      pc_nxt        = branch_target;
      flush_cnt_nxt = FLUSH_RELOAD;
      state_nxt     = BRANCH_STATE;
    end else begin
      case (state)
        BOOT: state_nxt = RUN;
        RUN: begin
          if (jump_req) begin
            pc_nxt = jump_target;
          end else if (stall_req) begin
            state_nxt = STALL;
          end else begin
            pc_nxt = pc + ADDR_W'(1);
            if (if_opcode == HALT_OP) state_nxt = HALT;
          end
        end
        STALL: if (!stall_req) state_nxt = RUN;
        FLUSH: begin
          pc_nxt = pc + ADDR_W'(1);
          if (flush_cnt == '0) state_nxt = RUN;
          else flush_cnt_nxt = flush_cnt - FLUSH_CNT_W'(1);
        end
        HALT: if (resume) state_nxt = RUN;
        default: state_nxt = BOOT;
      endcase
    end
  end

  // IF/ID controls decoded from state and the current-cycle requests.
  always_comb begin
    ifid_write = 1'b0;
    ifid_flush = 1'b0;
    case (state)
      RUN: begin
        if (branch_taken || jump_req) ifid_flush = 1'b1;
        else if (!stall_req)          ifid_write = 1'b1;
      end
      STALL:   ifid_flush = branch_taken;
      default: ifid_flush = 1'b1;
    endcase
  end

  assign rom_addr  = pc;
  assign fsm_state = state;

`ifdef FETCH_PERF_COUNTERS_EN
  logic stall_en, flush_en;

  assign stall_en = (state == STALL);
  assign flush_en = ifid_flush && (state != BOOT) && (state != HALT);

  fetch_perf_counter u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (stall_en),
    .count (stall_cycles)
  );

  fetch_perf_counter u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (flush_en),
    .count (flush_cycles)
  );
`else
  assign stall_cycles = '0;
  assign flush_cycles = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed cycle-by-cycle bench for fetch_sequencer (default parameters).
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        branch_taken;
  logic [9:0]  branch_target;
  logic        jump_req;
  logic [9:0]  jump_target;
  logic        stall_req;
  logic [5:0]  if_opcode;
  logic        resume;
  logic [9:0]  rom_addr;
  logic        ifid_write;
  logic        ifid_flush;
  logic [2:0]  fsm_state;
  logic [15:0] stall_cycles;
  logic [15:0] flush_cycles;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump_req      (jump_req),
    .jump_target   (jump_target),
    .stall_req     (stall_req),
    .if_opcode     (if_opcode),
    .resume        (resume),
    .rom_addr      (rom_addr),
    .ifid_write    (ifid_write),
    .ifid_flush    (ifid_flush),
    .fsm_state     (fsm_state),
    .stall_cycles  (stall_cycles),
    .flush_cycles  (flush_cycles)
  );

  // DUT acts on the falling edge; inputs are driven and outputs sampled after the rising edge.
  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    int rst; int bt; int btgt; int jr; int jtgt; int sr; int op; int res;
    int e_addr; int e_wr; int e_fl; int e_st; int e_sc; int e_fc;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(int rst, int bt, int btgt, int jr, int jtgt, int sr, int op,
                              int res, int ea, int ew, int ef, int es, int sc, int fc);
    vec_t v;
    v.rst = rst; v.bt = bt; v.btgt = btgt; v.jr = jr; v.jtgt = jtgt; v.sr = sr;
    v.op = op; v.res = res; v.e_addr = ea; v.e_wr = ew; v.e_fl = ef; v.e_st = es;
    v.e_sc = sc; v.e_fc = fc;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    @(posedge clk);
    reset         = v.rst[0];
    branch_taken  = v.bt[0];
    branch_target = 10'(v.btgt);
    jump_req      = v.jr[0];
    jump_target   = 10'(v.jtgt);
    stall_req     = v.sr[0];
    if_opcode     = 6'(v.op);
    resume        = v.res[0];
    #1;
  endtask

  task automatic apply(input vec_t v, input int idx);
    drive(v);
    check("rom_addr",   idx, int'(rom_addr),   v.e_addr);
    check("ifid_write", idx, int'(ifid_write), v.e_wr);
    check("ifid_flush", idx, int'(ifid_flush), v.e_fl);
    check("fsm_state",  idx, int'(fsm_state),  v.e_st);
`ifdef FETCH_PERF_COUNTERS_EN
    check("stall_cycles", idx, int'(stall_cycles), v.e_sc);
    check("flush_cycles", idx, int'(flush_cycles), v.e_fc);
`else
    check("stall_cycles", idx, int'(stall_cycles), 0);
    check("flush_cycles", idx, int'(flush_cycles), 0);
`endif
  endtask

  initial begin
    reset = 1'b0; branch_taken = 1'b0; branch_target = '0; jump_req = 1'b0;
    jump_target = '0; stall_req = 1'b0; if_opcode = '0; resume = 1'b0;
    repeat (2) @(negedge clk);

    //           rst bt btgt jr jtgt sr op res | addr wr fl st  sc fc
    vq.push_back(mk(1, 0,   0, 0,   0, 0, 0, 0,    0, 0, 1, 0,  0, 0));  // BOOT
    vq.push_back(mk(1, 0,   0, 0,   0, 0,62, 0,    0, 1, 0, 1,  0, 0));  // near-halt opcode runs on
    vq.push_back(mk(1, 0,   0, 0,   0, 0, 0, 0,    1, 1, 0, 1,  0, 0));
    vq.push_back(mk(1, 0,   0, 0,   0, 0, 0, 0,    2, 1, 0, 1,  0, 0));
    vq.push_back(mk(1, 0,   0, 0,   0, 0, 0, 0,    3, 1, 0, 1,  0, 0));
    vq.push_back(mk(1, 0,   0, 0,   0, 0, 0, 0,    4, 1, 0, 1,  0, 0));
    vq.push_back(mk(1, 1,  40, 0,   0, 0, 0, 0,    5, 0, 1, 1,  0, 0));  // branch at pc 5
    vq.push_back(mk(1, 0,   0, 0,   0, 0, 0, 0,   40, 0, 1, 3,  0, 1));
    vq.push_back(mk(1, 0,   0, 0,   0, 0, 0, 0,   41, 0, 1, 3,  0, 2));
    vq.push_back(mk(1, 0,   0, 0,   0, 0, 0, 0,   42, 1, 0, 1,  0, 3));
    vq.push_back(mk(1, 0,   0, 1,   8, 0, 0, 0,   43, 0, 1, 1,  0, 3));  // jump to 8
    vq.push_back(mk(1, 0,   0, 0,   0, 1, 0, 0,    8, 0, 0, 1,  0, 4));  // stall x3
    vq.push_back(mk(1, 0,   0, 0,   0, 1, 0, 0,    8, 0, 0, 2,  0, 4));
    vq.push_back(mk(1, 0,   0, 0,   0, 1, 0, 0,    8, 0, 0, 2,  1, 4));
    vq.push_back(mk(1, 0,   0, 0,   0, 0, 0, 0,    8, 0, 0, 2,  2, 4));
    vq.push_back(mk(1, 0,   0, 0,   0, 0, 0, 0,    8, 1, 0, 1,  3, 4));
    vq.push_back(mk(1, 0,   0, 0,   0, 0, 0, 0,    9, 1, 0, 1,  3, 4));
    vq.push_back(mk(1, 1, 100, 1, 200, 0, 0, 0,   10, 0, 1, 1,  3, 4));  // branch beats jump
    vq.push_back(mk(1, 0,   0, 0,   0, 0, 0, 0,  100, 0, 1, 3,  3, 5));
    vq.push_back(mk(1, 0,   0, 0,   0, 0, 0, 0,  101, 0, 1, 3,  3, 6));
    vq.push_back(mk(1, 0,   0, 0,   0, 0, 0, 0,  102, 1, 0, 1,  3, 7));
    vq.push_back(mk(1, 0,   0, 1,  12, 0, 0, 0,  103, 0, 1, 1,  3, 7));
    vq.push_back(mk(1, 0,   0, 0,   0, 0,63, 0,   12, 1, 0, 1,  3, 8));  // halt opcode
    vq.push_back(mk(1, 0,   0, 0,   0, 0, 0, 0,   13, 0, 1, 4,  3, 8));
    vq.push_back(mk(1, 0,   0, 0,   0, 0, 0, 1,   13, 0, 1, 4,  3, 8));  // resume
    vq.push_back(mk(1, 0,   0, 0,   0, 0, 0, 0,   13, 1, 0, 1,  3, 8));
    vq.push_back(mk(1, 0,   0, 0,   0, 0, 0, 0,   14, 1, 0, 1,  3, 8));
    vq.push_back(mk(1, 0,   0, 0,   0, 0,63, 0,   15, 1, 0, 1,  3, 8));
    vq.push_back(mk(1, 0,   0, 0,   0, 1, 0, 1,   16, 0, 1, 4,  3, 8));  // resume + stall
    vq.push_back(mk(1, 0,   0, 0,   0, 1, 0, 0,   16, 0, 0, 1,  3, 8));
    vq.push_back(mk(1, 0,   0, 0,   0, 0, 0, 0,   16, 0, 0, 2,  3, 8));
    vq.push_back(mk(1, 0,   0, 0,   0, 0, 0, 0,   16, 1, 0, 1,  4, 8));
    vq.push_back(mk(1, 0,   0, 0,   0, 0,63, 0,   17, 1, 0, 1,  4, 8));
    vq.push_back(mk(1, 1,  50, 0,   0, 0, 0, 0,   18, 0, 1, 4,  4, 8));  // branch out of HALT
    vq.push_back(mk(1, 0,   0, 0,   0, 0, 0, 0,   50, 0, 1, 3,  4, 8));
    vq.push_back(mk(1, 1,  60, 0,   0, 0, 0, 0,   51, 0, 1, 3,  4, 9));  // reload in FLUSH
    vq.push_back(mk(1, 0,   0, 1, 300, 1, 0, 0,   60, 0, 1, 3,  4,10));  // jump/stall ignored
    vq.push_back(mk(1, 0,   0, 0,   0, 0, 0, 0,   61, 0, 1, 3,  4,11));
    vq.push_back(mk(1, 0,   0, 0,   0, 0, 0, 0,   62, 1, 0, 1,  4,12));
    vq.push_back(mk(1, 0,   0, 0,   0, 1, 0, 0,   63, 0, 0, 1,  4,12));
    vq.push_back(mk(1, 1,  70, 0,   0, 1, 0, 0,   63, 0, 1, 2,  4,12));  // branch beats stall
    vq.push_back(mk(1, 0,   0, 0,   0, 0, 0, 0,   70, 0, 1, 3,  5,13));
    vq.push_back(mk(1, 0,   0, 0,   0, 0, 0, 0,   71, 0, 1, 3,  5,14));
    vq.push_back(mk(1, 0,   0, 0,   0, 0, 0, 0,   72, 1, 0, 1,  5,15));
    vq.push_back(mk(1, 1,  80, 0,   0, 0, 0, 0,   73, 0, 1, 1,  5,15));
    vq.push_back(mk(0, 0,   0, 0,   0, 0, 0, 0,   80, 0, 1, 3,  5,16));  // reset in FLUSH
    vq.push_back(mk(1, 0,   0, 0,   0, 0, 0, 0,    0, 0, 1, 0,  0, 0));
    vq.push_back(mk(1, 0,   0, 0,   0, 0, 0, 0,    0, 1, 0, 1,  0, 0));

    for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

    // Wrap-around: jump near the top of the address space and run through 1023 -> 0.
    begin
      vec_t v;
      logic [9:0] exp_pc;
      v = mk(1, 0, 0, 1, 1020, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(v);
      check("wrap_jump_flush", 100, int'(ifid_flush), 1);
      v.jr = 0;
      exp_pc = 10'd1020;
      for (int i = 0; i < 6; i++) begin
        drive(v);
        check("wrap_rom_addr", 101 + i, int'(rom_addr), int'(exp_pc));
        check("wrap_ifid_write", 101 + i, int'(ifid_write), 1);
        exp_pc = exp_pc + 10'd1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
